pwm_capture: RTL and testbench

Receive-side counterpart of the drum kit's PWM generator. Samples an asynchronous PWM input and measures the high time and full period in clk cycles. Reports each complete period with a one-cycle valid strobe, and flags a stuck or absent signal with a timeout. It sits on GPIO inputs that carry PWM from pads or sensor front-ends, and is also used in loopback to check the generator's output.

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_sync_edge.sv | 45 ++++
 rtl/pwm_capture.sv | 163 ++++++++++++++++
 tb/tb_pwm_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture pair.
//   - PWM_CNT_W_DEFAULT       : default counter width (also the generator's Top width)
//   - PWM_SYNC_STAGES_DEFAULT : default synchronizer depth for the capture input
//   - pwm_cap_state_t         : capture FSM state encoding
//   - pwm_cap_qual_edge()     : which synchronized edge ends the current phase
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_CNT_W_DEFAULT       = 16;
  localparam int PWM_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } pwm_cap_state_t;

  // A phase only ends on the edge that matters for it: WAIT_RISE and LOW wait
  // for a rise, HIGH waits for a fall. IDLE never has a qualifying edge.
  function automatic logic pwm_cap_qual_edge(input pwm_cap_state_t st,
                                             input logic           rise,
                                             input logic           fall);
    logic q;
    case (st)
      WAIT_RISE: q = rise;
      HIGH:      q = fall;
      LOW:       q = rise;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Brings an asynchronous level into the clk domain through a flop chain and
// produces single-cycle rise/fall strobes from the synchronized level.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (must be 2 or more)
// Ports:
//   clk      in  : system clock, rising edge
//   rst_n    in  : asynchronous active-low reset, clears all flops
//   async_in in  : asynchronous input level
//   level_s  out : synchronized level (last synchronizer stage)
//   rise     out : level_s went 0->1 this cycle
//   fall     out : level_s went 1->0 this cycle
// -----------------------------------------------------------------------------
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_dly_q;

  // Synchronizer chain plus one extra delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_s = sync_q[SYNC_STAGES-1];
  assign rise    = level_s & ~level_dly_q;
  assign fall    = ~level_s & level_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures high time (rise to fall) and period (rise to rise) of an
// asynchronous PWM input in clk cycles. Each completed period is reported
// with a one-cycle meas_valid strobe. A phase that lasts 2^CNT_W-1 cycles
// without its ending edge raises a sticky timeout and records the stuck level.
//
// Parameters:
//   CNT_W       : width of counters and measurement outputs
//   SYNC_STAGES : input synchronizer depth (2 or more)
// Ports:
//   clk         in  : system clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   en          in  : measurement enable; low forces IDLE, outputs hold
//   pwm_in      in  : asynchronous PWM input
//   period      out : last measured period
//   high_time   out : last measured high time
//   meas_valid  out : one-cycle strobe when period/high_time update
//   timeout     out : sticky no-edge indication, cleared by a report or en low
//   stuck_level out : synchronized input level when timeout was raised
// -----------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic pwm_s;
  logic rise_s;
  logic fall_s;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .level_s  (pwm_s),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  pwm_cap_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             meas_valid_q;
  logic             timeout_q;
  logic             stuck_level_q;

  logic             cnt_at_max_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             qual_edge_s;
  logic             saturate_s;

  // Counter helpers: the increment saturates so the count never wraps, which
  // matters when a fall lands exactly on MAX and LOW starts from a full count.
  always_comb begin
    cnt_at_max_s = (cnt_q == CNT_MAX);
    if (cnt_at_max_s) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
    qual_edge_s = pwm_cap_qual_edge(state_q, rise_s, fall_s);
    // The ending edge wins over saturation in the same cycle.
    saturate_s  = (state_q != IDLE) && cnt_at_max_s && !qual_edge_s;
  end

  // Capture FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      high_cnt_q    <= CNT_ZERO;
      period_q      <= CNT_ZERO;
      high_time_q   <= CNT_ZERO;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!en) begin
        // Abandon any partial measurement; results and stuck_level hold.
        state_q   <= IDLE;
        cnt_q     <= CNT_ZERO;
        timeout_q <= 1'b0;
      end else if (saturate_s) begin
        // Phase ran out of count: flag it and hunt for a fresh rise.
        timeout_q     <= 1'b1;
        stuck_level_q <= pwm_s;
        cnt_q         <= CNT_ZERO;
        state_q       <= WAIT_RISE;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= CNT_ZERO;
            state_q <= WAIT_RISE;
          end
          WAIT_RISE: begin
            // Any pulse already in progress is ignored; only a rise starts.
            if (rise_s) begin
              cnt_q   <= CNT_ONE;
              state_q <= HIGH;
            end else begin
              cnt_q   <= cnt_inc_s;
            end
          end
          HIGH: begin
            // cnt already counts the rise cycle as high cycle 1, so on the
            // fall cycle it equals the number of high cycles.
            if (fall_s) begin
              high_cnt_q <= cnt_q;
              cnt_q      <= cnt_inc_s;
              state_q    <= LOW;
            end else begin
              cnt_q      <= cnt_inc_s;
            end
          end
          LOW: begin
            if (rise_s) begin
              period_q     <= cnt_q;
              high_time_q  <= high_cnt_q;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b0;
              cnt_q        <= CNT_ONE;
              state_q      <= HIGH;
            end else begin
              cnt_q        <= cnt_inc_s;
            end
          end
          default: begin
            cnt_q   <= CNT_ZERO;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Drives pwm_in as a sequence of (high, low) pulse lengths. A pulse-level
// reference model decides which rises produce a report and pushes the
// expected (period, high_time, arrival cycle) into a scoreboard queue; a
// separate monitor pops and compares on every meas_valid.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int LAT   = 3;   // synchronizer (2) + report register (1)

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int per;
    int hi;
    int at;
  } exp_t;

  exp_t sb_q[$];

  // Pulse-level model state: a rise reports the previous pulse only when
  // that pulse started from a seen rise and fitted within MAXC cycles.
  bit armed    = 1'b0;
  int prev_h   = 0;
  int prev_l   = 0;
  int last_per = 0;
  int last_hi  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected report.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d: period=%0d high_time=%0d, none expected",
                 cyc, period, high_time);
      end else begin
        e = sb_q.pop_front();
        check("period", int'(period), e.per);
        check("high_time", int'(high_time), e.hi);
        check("valid_cycle", cyc, e.at);
        check("timeout_at_valid", int'(timeout), 0);
      end
    end
  end

  // Called at a falling clk edge: drives a rise and predicts its report.
  task automatic start_rise();
    exp_t e;
    if (armed) begin
      e.per = prev_h + prev_l;
      e.hi  = prev_h;
      e.at  = cyc + LAT;
      sb_q.push_back(e);
      last_per = e.per;
      last_hi  = e.hi;
    end
    pwm_in = 1'b1;
  endtask

  task automatic drive_pulse(input int h, input int l);
    start_rise();
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
    prev_h = h;
    prev_l = l;
    armed  = (h + l <= MAXC);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int v;
    rst_n  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_period", int'(period), 0);
    check("reset_high_time", int'(high_time), 0);
    check("reset_valid", int'(meas_valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_stuck", int'(stuck_level), 0);

    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) @(negedge clk);

    // Basic 3 high / 5 low.
    repeat (6) drive_pulse(3, 5);

    // Reset in the middle of a high phase discards everything.
    start_rise();
    repeat (6) @(negedge clk);
    rst_n    = 1'b0;
    armed    = 1'b0;
    last_per = 0;
    last_hi  = 0;
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_period", int'(period), 0);
    check("midreset_high_time", int'(high_time), 0);
    check("midreset_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    repeat (3) drive_pulse(3, 5);

    // Minimum pulse: toggle every cycle.
    repeat (10) drive_pulse(1, 1);

    // Random pulse shapes.
    repeat (30) drive_pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
    repeat (4) drive_pulse(int'($urandom_range(1, 120)), int'($urandom_range(1, 120)));

    // Period exactly MAXC reports; one more cycle times out in LOW.
    drive_pulse(100, MAXC - 100);
    drive_pulse(100, MAXC - 100 + 5);
    check("sat_timeout", int'(timeout), 1);
    check("sat_stuck_low", int'(stuck_level), 0);
    check("sat_period_hold", int'(period), last_per);
    drive_pulse(4, 4);
    check("timeout_sticky", int'(timeout), 1);
    drive_pulse(4, 4);
    drive_pulse(4, 4);

    // Held high after a rise: timeout exactly when the count saturates.
    start_rise();
    v = cyc;
    repeat (257) @(negedge clk);
    check("hold_no_early_timeout", int'(timeout), 0);
    @(negedge clk);
    check("hold_timeout", int'(timeout), 1);
    check("hold_stuck_high", int'(stuck_level), 1);
    check("hold_period", int'(period), last_per);
    check("hold_high_time", int'(high_time), last_hi);
    check("hold_elapsed", cyc - v, 258);
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    armed = 1'b0;

    // Resume 4/4: timeout clears on the next report.
    drive_pulse(4, 4);
    check("resume_timeout_still_set", int'(timeout), 1);
    drive_pulse(4, 4);
    drive_pulse(4, 4);

    // Stuck low, then drop en mid-pulse.
    drive_pulse(4, 300);
    check("low_timeout", int'(timeout), 1);
    check("low_stuck", int'(stuck_level), 0);
    start_rise();
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("endrop_valid", int'(meas_valid), 0);
    check("endrop_timeout_clear", int'(timeout), 0);
    check("endrop_period_hold", int'(period), last_per);
    en = 1'b1;
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    repeat (6) @(negedge clk);
    armed = 1'b0;
    repeat (3) drive_pulse(5, 7);
    repeat (3) drive_pulse(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));

    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
